// File: rtl/cc_row_sequencer.sv
// cc_row_sequencer: paces road rows into the row mux and strobes the row shift register and LFSR.
// Optional feature CC_ROWSEQ_DISTANCE_EN adds a saturating count of RUN rows on the distance output.
module cc_row_sequencer #(
  parameter int unsigned ROWSEQ_SELECTWIDTH = 2,
  parameter int unsigned ROWSEQ_SPEEDWIDTH  = 2,
  parameter int unsigned ROWSEQ_PERIODWIDTH = 24,
  parameter int unsigned ROWSEQ_BASE_PERIOD = 12500000,
  parameter int unsigned ROWSEQ_CLEAR_ROWS  = 4,
  parameter int unsigned ROWSEQ_GAP_ROWS    = 2,
  parameter int unsigned ROWSEQ_FLASH_ROWS  = 6
) (
  input  logic                          CC_ROWSEQ_CLOCK_50,
  input  logic                          CC_ROWSEQ_RESET_InLow,
  input  logic                          CC_ROWSEQ_start_InLow,
  input  logic                          CC_ROWSEQ_pause_InHigh,
  input  logic                          CC_ROWSEQ_gameover_InHigh,
  input  logic [ROWSEQ_SPEEDWIDTH-1:0]  CC_ROWSEQ_speed_InBUS,
  output logic [ROWSEQ_SELECTWIDTH-1:0] CC_ROWSEQ_select_OutBUS,
  output logic                          CC_ROWSEQ_load_OutHigh,
  output logic                          CC_ROWSEQ_randnext_OutHigh,
  output logic                          CC_ROWSEQ_busy_OutHigh,
  output logic [15:0]                   CC_ROWSEQ_distance_OutBUS
);

  localparam int unsigned RowCntWidth = 8;
  localparam int unsigned DistWidth   = 16;

  localparam logic [ROWSEQ_SELECTWIDTH-1:0] SelClear = ROWSEQ_SELECTWIDTH'(0);
  localparam logic [ROWSEQ_SELECTWIDTH-1:0] SelFill  = ROWSEQ_SELECTWIDTH'(1);
  localparam logic [ROWSEQ_SELECTWIDTH-1:0] SelRand  = ROWSEQ_SELECTWIDTH'(2);

  localparam logic [31:0]            BasePeriod = 32'(ROWSEQ_BASE_PERIOD);
  localparam logic [RowCntWidth-1:0] LastClear  = RowCntWidth'(ROWSEQ_CLEAR_ROWS - 1);
  localparam logic [RowCntWidth-1:0] LastGap    = RowCntWidth'(ROWSEQ_GAP_ROWS - 1);
  localparam logic [RowCntWidth-1:0] LastFlash  = RowCntWidth'(ROWSEQ_FLASH_ROWS - 1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StFlash} state_t;
  typedef enum logic {PhRandom, PhGap} phase_t;

  state_t                         stateQ, stateD;
  phase_t                         phaseQ, phaseD;
  logic [RowCntWidth-1:0]         rowCntQ, rowCntD;
  logic [ROWSEQ_PERIODWIDTH-1:0]  prescQ, prescD;
  logic [ROWSEQ_SELECTWIDTH-1:0]  selectQ, selectD;
  logic                           loadQ, loadD;
  logic                           randNextQ, randNextD;
  logic                           busyQ, busyD;

  logic [ROWSEQ_PERIODWIDTH-1:0]  reloadC;
  logic                           abortC;
  logic                           tickC;

  // Row period at the current speed; only consumed at a prescaler reload.
  assign reloadC = ROWSEQ_PERIODWIDTH'((BasePeriod >> CC_ROWSEQ_speed_InBUS) - 32'd1);

  always_ff @(posedge CC_ROWSEQ_CLOCK_50 or negedge CC_ROWSEQ_RESET_InLow) begin
    if (!CC_ROWSEQ_RESET_InLow) begin
      stateQ    <= StIdle;
      phaseQ    <= PhRandom;
      rowCntQ   <= '0;
      prescQ    <= '0;
      selectQ   <= SelClear;
      loadQ     <= 1'b0;
      randNextQ <= 1'b0;
      busyQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      phaseQ    <= phaseD;
      rowCntQ   <= rowCntD;
      prescQ    <= prescD;
      selectQ   <= selectD;
      loadQ     <= loadD;
      randNextQ <= randNextD;
      busyQ     <= busyD;
    end
  end

  always_comb begin
    stateD    = stateQ;
    phaseD    = phaseQ;
    rowCntD   = rowCntQ;
    prescD    = prescQ;
    selectD   = selectQ;
    loadD     = 1'b0;
    randNextD = 1'b0;
    abortC    = CC_ROWSEQ_gameover_InHigh && (stateQ == StClear || stateQ == StRun);
    tickC     = (prescQ == '0);

    if (abortC) begin
      // Game over beats a coincident tick and ignores pause; the aborted row is never loaded.
      stateD  = StFlash;
      rowCntD = '0;
      prescD  = reloadC;
    end else if (!CC_ROWSEQ_pause_InHigh) begin
      if (stateQ != StIdle) begin
        prescD = tickC ? reloadC : prescQ - ROWSEQ_PERIODWIDTH'(1);
        loadD  = tickC;
      end
      case (stateQ)
        StIdle: begin
          selectD = SelClear;
          if (!CC_ROWSEQ_start_InLow) begin
            stateD  = StClear;
            rowCntD = '0;
            prescD  = reloadC;
          end
        end
        StClear: begin
          if (tickC) begin
            selectD = SelClear;
            if (rowCntQ == LastClear) begin
              stateD  = StRun;
              phaseD  = PhRandom;
              rowCntD = '0;
            end else begin
              rowCntD = rowCntQ + RowCntWidth'(1);
            end
          end
        end
        StRun: begin
          if (tickC) begin
            if (phaseQ == PhRandom) begin
              selectD   = SelRand;
              randNextD = 1'b1;
              phaseD    = PhGap;
              rowCntD   = '0;
            end else begin
              selectD = SelClear;
              if (rowCntQ == LastGap) begin
                phaseD  = PhRandom;
                rowCntD = '0;
              end else begin
                rowCntD = rowCntQ + RowCntWidth'(1);
              end
            end
          end
        end
        StFlash: begin
          if (tickC) begin
            selectD = rowCntQ[0] ? SelClear : SelFill;
            if (rowCntQ == LastFlash) begin
              rowCntD = '0;
              stateD  = CC_ROWSEQ_start_InLow ? StIdle : StClear;
            end else begin
              rowCntD = rowCntQ + RowCntWidth'(1);
            end
          end
        end
        default: stateD = StIdle;
      endcase
    end

    busyD = (stateD != StIdle);
  end

  assign CC_ROWSEQ_select_OutBUS    = selectQ;
  assign CC_ROWSEQ_load_OutHigh     = loadQ;
  assign CC_ROWSEQ_randnext_OutHigh = randNextQ;
  assign CC_ROWSEQ_busy_OutHigh     = busyQ;

`ifdef CC_ROWSEQ_DISTANCE_EN
  logic [DistWidth-1:0] distanceQ, distanceD;
  logic                 runLoadC;
  logic                 enterClearC;

  assign runLoadC    = loadD && (stateQ == StRun);
  assign enterClearC = (stateD == StClear) && (stateQ != StClear);

  // Distance restarts with each game and saturates instead of wrapping.
  always_comb begin
    distanceD = distanceQ;
    if (enterClearC) begin
      distanceD = '0;
    end else if (runLoadC && (distanceQ != '1)) begin
      distanceD = distanceQ + DistWidth'(1);
    end
  end

  always_ff @(posedge CC_ROWSEQ_CLOCK_50 or negedge CC_ROWSEQ_RESET_InLow) begin
    if (!CC_ROWSEQ_RESET_InLow) begin
      distanceQ <= '0;
    end else begin
      distanceQ <= distanceD;
    end
  end

  assign CC_ROWSEQ_distance_OutBUS = distanceQ;
`else
  assign CC_ROWSEQ_distance_OutBUS = '0;
`endif

endmodule

// File: tb/tb_cc_row_sequencer.sv
// Bench for cc_row_sequencer: directed load-spacing table, multi-cycle corner sequences and
// randomized stimulus scored every cycle against a row-index based reference model.
module tb_cc_row_sequencer;

  localparam int BasePeriod = 16;
  localparam int ClearRows  = 4;
  localparam int GapRows    = 2;
  localparam int FlashRows  = 6;
  localparam int WaitLimit  = 200;

  localparam int ModeIdle  = 0;
  localparam int ModeGame  = 1;
  localparam int ModeFlash = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        startN = 1'b1;
  logic        pause = 1'b0;
  logic        gameover = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic [1:0]  sel;
  logic        load;
  logic        randNext;
  logic        busy;
  logic [15:0] distance;

  int nCompared = 0;
  int nFailed   = 0;

  cc_row_sequencer #(
    .ROWSEQ_BASE_PERIOD(BasePeriod),
    .ROWSEQ_CLEAR_ROWS (ClearRows),
    .ROWSEQ_GAP_ROWS   (GapRows),
    .ROWSEQ_FLASH_ROWS (FlashRows)
  ) dut (
    .CC_ROWSEQ_CLOCK_50        (clk),
    .CC_ROWSEQ_RESET_InLow     (rstN),
    .CC_ROWSEQ_start_InLow     (startN),
    .CC_ROWSEQ_pause_InHigh    (pause),
    .CC_ROWSEQ_gameover_InHigh (gameover),
    .CC_ROWSEQ_speed_InBUS     (speed),
    .CC_ROWSEQ_select_OutBUS   (sel),
    .CC_ROWSEQ_load_OutHigh    (load),
    .CC_ROWSEQ_randnext_OutHigh(randNext),
    .CC_ROWSEQ_busy_OutHigh    (busy),
    .CC_ROWSEQ_distance_OutBUS (distance)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    nCompared++;
    if (got != want) begin
      nFailed++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference model: a game is one row index; its select follows from where the index
  // falls in the clear prefix or the random/gap cycle.
  int mMode = ModeIdle;
  int mRow = 0;
  int mRemain = 0;
  int mSel = 0;
  int mLoad = 0;
  int mRand = 0;
  int mDist = 0;

  function automatic int rowPeriod(input logic [1:0] s);
    return (BasePeriod >> s) - 1;
  endfunction

  function automatic int gameSel(input int r);
    if (r < ClearRows) return 0;
    return (((r - ClearRows) % (GapRows + 1)) == 0) ? 2 : 0;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mMode = ModeIdle; mRow = 0; mRemain = 0; mSel = 0; mLoad = 0; mRand = 0; mDist = 0;
    end else begin
      mLoad = 0;
      mRand = 0;
      if (gameover && mMode == ModeGame) begin
        mMode = ModeFlash; mRow = 0; mRemain = rowPeriod(speed);
      end else if (!pause) begin
        if (mMode == ModeIdle) begin
          mSel = 0;
          if (!startN) begin
            mMode = ModeGame; mRow = 0; mRemain = rowPeriod(speed); mDist = 0;
          end
        end else if (mRemain > 0) begin
          mRemain--;
        end else begin
          mRemain = rowPeriod(speed);
          mLoad = 1;
          if (mMode == ModeGame) begin
            mSel = gameSel(mRow);
            mRand = (mSel == 2) ? 1 : 0;
            if (mRow >= ClearRows && mDist < 65535) mDist++;
            mRow++;
          end else begin
            mSel = (mRow % 2 == 0) ? 1 : 0;
            mRow++;
            if (mRow == FlashRows) begin
              mRow = 0;
              if (!startN) begin
                mMode = ModeGame; mDist = 0;
              end else begin
                mMode = ModeIdle;
              end
            end
          end
        end
      end
    end
  end

  bit chkOn = 1'b0;
  int expDist;

  always @(negedge clk) begin
    if (chkOn) begin
`ifdef CC_ROWSEQ_DISTANCE_EN
      expDist = mDist;
`else
      expDist = 0;
`endif
      nCompared++;
      if (int'(sel) != mSel || int'(load) != mLoad || int'(randNext) != mRand ||
          int'(busy) != (mMode != ModeIdle ? 1 : 0) || int'(distance) != expDist) begin
        nFailed++;
        $display("FAIL model @%0t: sel/load/rand/busy/dist got %0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                 $time, sel, load, randNext, busy, distance,
                 mSel, mLoad, mRand, (mMode != ModeIdle ? 1 : 0), expDist);
      end
    end
  end

  task automatic waitLoad(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!load && n < WaitLimit);
  endtask

  task automatic pulseStart();
    startN = 1'b0;
    @(posedge clk); #1;
    startN = 1'b1;
  endtask

  typedef struct {
    logic [1:0] speed;
    int         gap;
    int         sel;
    int         rnd;
  } vec_t;

  vec_t tbl[16];
  int   speedTbl[16] = '{0,0,0,0,0,0,0,0,0,0,2,2,2,2,0,0};
  int   gapTbl[16]   = '{16,16,16,16,16,16,16,16,16,16,16,4,4,4,4,16};
  int   selTbl[16]   = '{0,0,0,0,2,0,0,2,0,0,2,0,0,2,0,0};
  int   wantDist;

  initial begin
    int n;
    int quiet;

    for (int i = 0; i < 16; i++) begin
      tbl[i].speed = 2'(speedTbl[i]);
      tbl[i].gap   = gapTbl[i];
      tbl[i].sel   = selTbl[i];
      tbl[i].rnd   = (selTbl[i] == 2) ? 1 : 0;
    end
`ifdef CC_ROWSEQ_DISTANCE_EN
    wantDist = 10;
`else
    wantDist = 0;
`endif

    // Power-on reset.
    #2 rstN = 1'b0;
    #1 chkOn = 1'b1;
    check("reset sel", int'(sel), 0);
    check("reset load", int'(load), 0);
    check("reset busy", int'(busy), 0);
    check("reset distance", int'(distance), 0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    // Start at speed 0, then a mid-row speed change; table gives spacing and select per load.
    pulseStart();
    for (int i = 0; i < 16; i++) begin
      speed = tbl[i].speed;
      waitLoad(n);
      check($sformatf("row%0d gap", i), n, tbl[i].gap);
      check($sformatf("row%0d sel", i), int'(sel), tbl[i].sel);
      check($sformatf("row%0d randnext", i), int'(randNext), tbl[i].rnd);
    end

    // Pause 40 cycles, 5 cycles into a row: silent, then the remaining 11 cycles.
    repeat (5) @(posedge clk);
    #1 pause = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (load || randNext) quiet++;
    end
    check("pause strobes", quiet, 0);
    pause = 1'b0;
    waitLoad(n);
    check("pause resume gap", n, 11);
    check("pause resume sel", int'(sel), 2);

    // Game over coinciding with a tick: no load, then six alternating flash rows.
    repeat (15) @(posedge clk);
    #1 gameover = 1'b1;
    @(posedge clk); #1;
    check("gameover tick load", int'(load), 0);
    check("gameover busy", int'(busy), 1);
    gameover = 1'b0;
    for (int i = 0; i < FlashRows; i++) begin
      waitLoad(n);
      check($sformatf("flash%0d gap", i), n, 16);
      check($sformatf("flash%0d sel", i), int'(sel), (i % 2 == 0) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("after flash busy", int'(busy), 0);
    check("after flash sel", int'(sel), 0);

    // Distance: 4 clear rows + 10 run rows, held through flash and idle.
    pulseStart();
    for (int i = 0; i < ClearRows + 10; i++) waitLoad(n);
    check("distance after 10 run rows", int'(distance), wantDist);
    gameover = 1'b1;
    @(posedge clk); #1;
    gameover = 1'b0;
    for (int i = 0; i < FlashRows; i++) waitLoad(n);
    repeat (3) @(posedge clk);
    #1 check("distance held in idle", int'(distance), wantDist);

    // Reset mid-RUN clears outputs at once; the next game starts with clear rows.
    pulseStart();
    for (int i = 0; i < 6; i++) waitLoad(n);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    check("midreset sel", int'(sel), 0);
    check("midreset load", int'(load), 0);
    check("midreset busy", int'(busy), 0);
    check("midreset distance", int'(distance), 0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;
    pulseStart();
    for (int i = 0; i < ClearRows + 1; i++) begin
      waitLoad(n);
      check($sformatf("restart%0d gap", i), n, 16);
      check($sformatf("restart%0d sel", i), int'(sel), (i < ClearRows) ? 0 : 2);
    end

    // Randomized stimulus, scored by the model every cycle.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) startN = ~startN;
      if ($urandom_range(0, 59) == 0) pause = ~pause;
      gameover = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    startN = 1'b1; pause = 1'b0; gameover = 1'b0;
    repeat (4) @(posedge clk);
    #1 chkOn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
